// File: rtl/tcad_delay_if.sv
// Host-to-TCAD stream bundle: init/run strobes, packed configuration word and ex_bus.
interface tcad_delay_if #(
  parameter int unsigned H_C_W = 832,
  parameter int unsigned EX_W  = 44
);
  logic             init;
  logic             run;
  logic [H_C_W-1:0] host_controller;
  logic [EX_W-1:0]  ex_bus;

  // Producer side of the bundle
  modport master (
    output init,
    output run,
    output host_controller,
    output ex_bus
  );

  // Consumer side of the bundle
  modport slave (
    input init,
    input run,
    input host_controller,
    input ex_bus
  );
endinterface

// File: rtl/tcad_delay.sv
// Alignment stage: delays init, run, host_controller and ex_bus by DEPTH cycles
// so all four reach the TCAD core cycle-aligned. No field is decoded or altered.
module tcad_delay #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned PE_INST_W  = 48,
  parameter int unsigned LSU_INST_W = 11,
  parameter int unsigned SPM_INST_W = 20,
  parameter int unsigned A_W        = 10
) (
  input  logic               clk,
  input  logic               rst,
  tcad_delay_if.slave        in_if,
  tcad_delay_if.master       out_if
);

  localparam int unsigned CONFIG_W = LSU_INST_W + 4 * PE_INST_W;
  localparam int unsigned H_C_W    = SPM_INST_W + 4 * CONFIG_W;
  localparam int unsigned EX_W     = A_W + 34;
  // One stage word carries every stream: {init, run, host_controller, ex_bus}
  localparam int unsigned STAGE_W  = 2 + H_C_W + EX_W;

  // Bit positions of each stream inside a stage word
  localparam int unsigned EX_LSB   = 0;
  localparam int unsigned HC_LSB   = EX_W;
  localparam int unsigned RUN_BIT  = EX_W + H_C_W;
  localparam int unsigned INIT_BIT = EX_W + H_C_W + 1;

  logic [STAGE_W-1:0] in_word;

  // Gather the input streams into one stage word
  assign in_word = {in_if.init, in_if.run, in_if.host_controller, in_if.ex_bus};

  if (DEPTH > 8) begin : g_bad_depth
    $error("tcad_delay: DEPTH must be in 0..8");
  end

  if (DEPTH == 0) begin : g_bypass
    // Clock and reset have no role in pass-through mode
    logic unused_bypass;
    assign unused_bypass = clk ^ rst;

    // Combinational pass-through, reset has no effect
    assign out_if.init            = in_word[INIT_BIT];
    assign out_if.run             = in_word[RUN_BIT];
    assign out_if.host_controller = in_word[HC_LSB +: H_C_W];
    assign out_if.ex_bus          = in_word[EX_LSB +: EX_W];
  end else begin : g_pipe
    logic [STAGE_W-1:0] pipe_q [DEPTH];
    logic [STAGE_W-1:0] pipe_d [DEPTH];

    // Next stage contents: shift by one each cycle, reset clears every stage
    always_comb begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        pipe_d[k] = '0;
      end
      if (!rst) begin
        pipe_d[0] = in_word;
        for (int k = 1; k < int'(DEPTH); k++) begin
          pipe_d[k] = pipe_q[k-1];
        end
      end
    end

    // Stage registers, loaded every rising edge with no enable
    always_ff @(posedge clk) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end

    // Outputs come straight from the last stage register
    assign out_if.init            = pipe_q[DEPTH-1][INIT_BIT];
    assign out_if.run             = pipe_q[DEPTH-1][RUN_BIT];
    assign out_if.host_controller = pipe_q[DEPTH-1][HC_LSB +: H_C_W];
    assign out_if.ex_bus          = pipe_q[DEPTH-1][EX_LSB +: EX_W];
  end

endmodule

// File: tb/tb_tcad_delay.sv
// Self-checking bench for tcad_delay: DEPTH=0, 1 and 3 instances share one input
// bundle and are compared against a history-based reference model.
module tb_tcad_delay;

  localparam int unsigned H_C_W = 832;
  localparam int unsigned EX_W  = 44;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tcad_delay_if #(.H_C_W(H_C_W), .EX_W(EX_W)) in_if ();
  tcad_delay_if #(.H_C_W(H_C_W), .EX_W(EX_W)) o0 ();
  tcad_delay_if #(.H_C_W(H_C_W), .EX_W(EX_W)) o1 ();
  tcad_delay_if #(.H_C_W(H_C_W), .EX_W(EX_W)) o3 ();

  tcad_delay #(.DEPTH(0)) u_d0 (.clk(clk), .rst(rst), .in_if(in_if.slave), .out_if(o0.master));
  tcad_delay #(.DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .in_if(in_if.slave), .out_if(o1.master));
  tcad_delay #(.DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .in_if(in_if.slave), .out_if(o3.master));

  // What was presented at one rising edge
  typedef struct {
    logic             r;
    logic             init;
    logic             run;
    logic [H_C_W-1:0] hc;
    logic [EX_W-1:0]  ex;
  } smp_t;

  smp_t hist[$];
  int   n_tot = 0;
  int   n_bad = 0;

  // Count one comparison and report it if it differs
  task automatic chk(input string tag, input logic [H_C_W-1:0] obs, input logic [H_C_W-1:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Output after the latest edge of a D-deep delay: the sample taken D-1 edges ago,
  // unless any reset edge happened since then (or history is too short) -> zero.
  function automatic smp_t expect_at(input int d);
    smp_t e;
    int   n;
    n = hist.size() - 1;
    e = '{r: 1'b0, init: 1'b0, run: 1'b0, hc: '0, ex: '0};
    if (n - d + 1 < 0) return e;
    for (int k = n - d + 1; k <= n; k++) begin
      if (hist[k].r) return e;
    end
    e = hist[n - d + 1];
    e.r = 1'b0;
    return e;
  endfunction

  function automatic logic [H_C_W-1:0] rnd_hc();
    logic [H_C_W-1:0] v;
    for (int k = 0; k < int'(H_C_W / 32); k++) begin
      v[k*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  // Apply one cycle of inputs, check the pass-through instance, clock, check the pipes
  task automatic step(input logic r, input logic i, input logic rn,
                      input logic [H_C_W-1:0] hc, input logic [EX_W-1:0] ex);
    smp_t e;
    smp_t s;
    rst                = r;
    in_if.init            = i;
    in_if.run             = rn;
    in_if.host_controller = hc;
    in_if.ex_bus          = ex;
    #1;
    chk("d0_init", H_C_W'(o0.init), H_C_W'(i));
    chk("d0_run",  H_C_W'(o0.run),  H_C_W'(rn));
    chk("d0_hc",   o0.host_controller, hc);
    chk("d0_ex",   H_C_W'(o0.ex_bus), H_C_W'(ex));
    @(posedge clk);
    s = '{r: r, init: i, run: rn, hc: hc, ex: ex};
    hist.push_back(s);
    #1;
    e = expect_at(1);
    chk("d1_init", H_C_W'(o1.init), H_C_W'(e.init));
    chk("d1_run",  H_C_W'(o1.run),  H_C_W'(e.run));
    chk("d1_hc",   o1.host_controller, e.hc);
    chk("d1_ex",   H_C_W'(o1.ex_bus), H_C_W'(e.ex));
    e = expect_at(3);
    chk("d3_init", H_C_W'(o3.init), H_C_W'(e.init));
    chk("d3_run",  H_C_W'(o3.run),  H_C_W'(e.run));
    chk("d3_hc",   o3.host_controller, e.hc);
    chk("d3_ex",   H_C_W'(o3.ex_bus), H_C_W'(e.ex));
  endtask

  initial begin
    logic [EX_W-1:0]  ex_w;
    logic [H_C_W-1:0] hc_w;
    logic [47:0]      pe3;

    rst                   = 1'b1;
    in_if.init            = 1'b0;
    in_if.run             = 1'b0;
    in_if.host_controller = '0;
    in_if.ex_bus          = '0;

    // Reset held with every input at all ones: registered outputs stay zero
    repeat (3) begin
      step(1'b1, 1'b1, 1'b1, '1, '1);
      chk("rst_d1_hc", o1.host_controller, '0);
      chk("rst_d3_ex", H_C_W'(o3.ex_bus), '0);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);

    // init rise with row0 pe_3 instruction appears one edge later on DEPTH=1
    pe3  = 48'h004708078d9f;
    hc_w = '0;
    hc_w[47:0] = pe3;
    step(1'b0, 1'b1, 1'b0, hc_w, '0);
    chk("t2_init", H_C_W'(o1.init), H_C_W'(1'b1));
    chk("t2_hc",   H_C_W'(o1.host_controller[47:0]), H_C_W'(pe3));

    // Single-cycle ex_bus write, then a new value with no hold
    ex_w = {1'b1, 1'b0, 10'd5, 32'd6};
    step(1'b0, 1'b1, 1'b0, hc_w, ex_w);
    chk("t3_ex", H_C_W'(o1.ex_bus), H_C_W'(44'h805_0000_0006));
    step(1'b0, 1'b0, 1'b0, '0, 44'h123);
    chk("t3_nohold", H_C_W'(o1.ex_bus), H_C_W'(44'h123));

    // run pattern 1/0/0/0/1 through both pipes
    foreach (hist[k]) begin end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, (k == 0 || k == 4) ? 1'b1 : 1'b0, '0, '0);
    end

    // Reset while a run pulse sits inside the DEPTH=3 pipe: it must vanish
    step(1'b0, 1'b0, 1'b1, rnd_hc(), 44'hfff_ffff_ffff);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      chk("t5_run", H_C_W'(o3.run), '0);
      chk("t5_ex",  H_C_W'(o3.ex_bus), '0);
    end

    // Random traffic with occasional resets
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
           1'($urandom), 1'($urandom), rnd_hc(),
           {12'($urandom), 32'($urandom)});
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
